// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO responder.
//   - Word offsets (address[7:2]) of the register map.
//   - Bit positions inside the STATUS and CTRL registers.
//   - status_word(): packs the FIFO flags into the STATUS layout.
// The optional timer registers exist only when MMIO_TIMER_EN is defined;
// their offsets are kept here unconditionally so the map is in one place.
package mmio_pkg;

  // Word offsets: byte offset >> 2.
  localparam logic [5:0] OFF_DATA   = 6'h00;  // byte 0x00
  localparam logic [5:0] OFF_STATUS = 6'h01;  // byte 0x04
  localparam logic [5:0] OFF_TCMP   = 6'h02;  // byte 0x08
  localparam logic [5:0] OFF_TCNT   = 6'h03;  // byte 0x0C
  localparam logic [5:0] OFF_CTRL   = 6'h04;  // byte 0x10

  // STATUS bits
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  // CTRL bits
  localparam int CTRL_TEN  = 0;
  localparam int CTRL_IEN  = 1;
  localparam int CTRL_PEND = 2;

  function automatic logic [31:0] status_word(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]                    = full;
    w[STAT_EMPTY]                   = empty;
    w[STAT_OVF]                     = ovf;
    w[STAT_CNT_LSB+7:STAT_CNT_LSB]  = count;
    return w;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// mmio_fifo: synchronous byte FIFO, DEPTH entries (power of two).
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   i_push, i_din  - write request and byte; ignored while full
//   i_pop          - read request; ignored while empty
//   o_dout         - head byte, 0 while empty
//   o_full, o_empty, o_count - occupancy, all from registered state
module mmio_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [7:0]    i_din,
  input  logic          i_pop,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Full/empty come from start-of-cycle state, so a push into a full FIFO
  // is dropped even when a pop frees a slot on the same edge.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Gate the head so the output reads 0 while the (unreset) storage is stale.
  assign o_dout = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O responder on the CPU memory bus.
// Decodes a 256-byte window at BASE_ADDR (bits [31:8] compared) and answers
// reads one cycle later, like main memory.
// Register map (byte offsets): 0x00 DATA (W), 0x04 STATUS, 0x08 TIMER_CMP,
// 0x0C TIMER_CNT, 0x10 CTRL. Timer registers, CTRL and irq are built only
// when the macro MMIO_TIMER_EN is defined; otherwise those offsets read 0.
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   address, wr, wdata - CPU bus transaction (wr=1 write, 0 read)
//   rdata, rd_hit      - registered read data and "rdata is ours" flag
//   out_data, out_valid, out_ready - byte stream from the output FIFO
//   irq                - level timer interrupt (PEND & IEN)
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rd_hit,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic        w_hit;
  logic [5:0]  w_off;
  logic        w_wr_hit;
  logic        w_rd_hit;
  logic        w_wr_data;
  logic        w_wr_status;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic [7:0]  w_head;
  logic        w_pop;
  logic [31:0] w_rmux;
  logic        w_unused;

  logic [31:0] r_rdata;
  logic        r_rd_hit;
  logic        r_ovf;

  // Byte lane bits are irrelevant to a word-mapped register file.
  assign w_unused = ^{address[1:0], wdata};

  assign w_hit       = (address[31:8] == BASE_ADDR[31:8]);
  assign w_off       = address[7:2];
  assign w_wr_hit    = w_hit & wr;
  assign w_rd_hit    = w_hit & ~wr;
  assign w_wr_data   = w_wr_hit & (w_off == OFF_DATA);
  assign w_wr_status = w_wr_hit & (w_off == OFF_STATUS);

  // ---------------------------------------------------------------- FIFO
  assign w_pop = ~w_empty & out_ready;

  mmio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_wr_data),
    .i_din   (wdata[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_data  = w_head;
  assign out_valid = ~w_empty;

  // Sticky overflow; a drop on the same edge as a W1C keeps it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_wr_data && w_full) begin
      r_ovf <= 1'b1;
    end else if (w_wr_status && wdata[STAT_OVF]) begin
      r_ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------- timer
`ifdef MMIO_TIMER_EN
  logic [31:0] r_tcmp;
  logic [31:0] r_tcnt;
  logic        r_ten;
  logic        r_ien;
  logic        r_pend;
  logic        w_wr_tcmp;
  logic        w_wr_tcnt;
  logic        w_wr_ctrl;
  logic        w_tmatch;

  assign w_wr_tcmp = w_wr_hit & (w_off == OFF_TCMP);
  assign w_wr_tcnt = w_wr_hit & (w_off == OFF_TCNT);
  assign w_wr_ctrl = w_wr_hit & (w_off == OFF_CTRL);
  assign w_tmatch  = r_ten & (r_tcnt == r_tcmp);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tcmp <= '0;
      r_tcnt <= '0;
      r_ten  <= 1'b0;
      r_ien  <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_wr_tcmp) r_tcmp <= wdata;

      // CPU write beats both the reload and the increment.
      if (w_wr_tcnt)     r_tcnt <= wdata;
      else if (w_tmatch) r_tcnt <= '0;
      else if (r_ten)    r_tcnt <= r_tcnt + 32'd1;

      if (w_wr_ctrl) begin
        r_ten <= wdata[CTRL_TEN];
        r_ien <= wdata[CTRL_IEN];
      end

      // Set wins over a simultaneous W1C so no expiry is ever lost.
      if (w_tmatch)                            r_pend <= 1'b1;
      else if (w_wr_ctrl && wdata[CTRL_PEND])  r_pend <= 1'b0;
    end
  end

  assign irq = r_pend & r_ien;
`else
  assign irq = 1'b0;
`endif

  // ------------------------------------------------------------ read mux
  always_comb begin
    w_rmux = '0;
    case (w_off)
      OFF_STATUS: w_rmux = status_word(w_full, w_empty, r_ovf, 8'(w_count));
`ifdef MMIO_TIMER_EN
      OFF_TCMP:   w_rmux = r_tcmp;
      OFF_TCNT:   w_rmux = r_tcnt;
      OFF_CTRL: begin
        w_rmux[CTRL_TEN]  = r_ten;
        w_rmux[CTRL_IEN]  = r_ien;
        w_rmux[CTRL_PEND] = r_pend;
      end
`endif
      default:    w_rmux = '0;
    endcase
  end

  // Non-hit cycles and writes return 0 so the load mux never sees stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rd_hit <= 1'b0;
    end else if (w_rd_hit) begin
      r_rdata  <= w_rmux;
      r_rd_hit <= 1'b1;
    end else begin
      r_rdata  <= '0;
      r_rd_hit <= 1'b0;
    end
  end

  assign rdata  = r_rdata;
  assign rd_hit = r_rd_hit;

endmodule
